hub_counter_poller: RTL

HUB_COUNTER_POLLER -- requirements
Module: hub_counter_poller

---
 rtl/hub_counter_poller_if.sv | 24 ++
 rtl/hub_counter_poller.sv | 131 +++++++++++++
 2 files changed

// File: rtl/hub_counter_poller_if.sv
// Wishbone classic bus bundle between the counter poller (master) and a register hub (slave).
interface hub_counter_poller_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  wb_cyc;
    logic                  wb_stb;
    logic                  wb_we;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data_write;
    logic [DATA_WIDTH-1:0] wb_data_read;
    logic                  wb_ack;
    logic                  wb_err;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_addr, wb_data_write,
        input  wb_data_read, wb_ack, wb_err
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_addr, wb_data_write,
        output wb_data_read, wb_ack, wb_err
    );
endinterface

// File: rtl/hub_counter_poller.sv
// Periodic / on-demand sweep reader: reads REG_COUNT hub registers over Wishbone classic
// and reports each result as a one-cycle sample pulse, then a sweep_done pulse.
module hub_counter_poller #(
    parameter int REG_COUNT  = 8,
    parameter int BASE_ADDR  = 0,
    parameter int STRIDE     = 1,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int PERIOD     = 125000,
    parameter int TIMEOUT    = 15,
    localparam int IDX_W     = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  trigger,
    hub_counter_poller_if.master  bus,
    output logic                  busy,
    output logic                  sample_valid,
    output logic [IDX_W-1:0]      sample_index,
    output logic [DATA_WIDTH-1:0] sample_data,
    output logic                  sample_error,
    output logic                  sweep_done
);
    localparam int PER_W = $clog2(PERIOD);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REG_COUNT - 1);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [PER_W-1:0] per_q;
    logic             pending_q;
    logic             expire;
    logic             launch;
    logic             rd_done;
    logic             rd_fail;
    logic             last_done;

    assign expire = enable && (per_q == PER_LAST);

    assign bus.wb_cyc        = (state_q == REQ);
    assign bus.wb_stb        = (state_q == REQ);
    assign bus.wb_we         = 1'b0;
    assign bus.wb_data_write = '0;
    assign bus.wb_addr       = (state_q == REQ) ?
                               ADDR_WIDTH'(BASE_ADDR + int'(idx_q) * STRIDE) : '0;
    assign busy              = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        launch    = 1'b0;
        rd_done   = 1'b0;
        rd_fail   = 1'b0;
        last_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && (pending_q || trigger || expire)) begin
                    state_d = REQ;
                    idx_d   = '0;
                    tmo_d   = '0;
                    launch  = 1'b1;
                end
            end
            REQ: begin
                // err wins over a simultaneous ack; a silent slave is cut off after TIMEOUT cycles
                if (bus.wb_err) begin
                    rd_done = 1'b1;
                    rd_fail = 1'b1;
                end else if (bus.wb_ack) begin
                    rd_done = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    rd_done = 1'b1;
                    rd_fail = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
                if (rd_done) state_d = GAP;
            end
            GAP: begin
                if (idx_q == IDX_LAST) begin
                    state_d   = IDLE;
                    last_done = 1'b1;
                end else begin
                    state_d = REQ;
                    idx_d   = idx_q + 1'b1;
                    tmo_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            tmo_q        <= '0;
            per_q        <= '0;
            pending_q    <= 1'b0;
            sample_valid <= 1'b0;
            sample_index <= '0;
            sample_data  <= '0;
            sample_error <= 1'b0;
            sweep_done   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            per_q   <= (!enable || expire) ? '0 : per_q + 1'b1;
            // requests arriving mid-sweep collapse into a single pending start
            if (!enable || launch)
                pending_q <= 1'b0;
            else if (trigger || expire)
                pending_q <= 1'b1;
            sample_valid <= rd_done;
            sweep_done   <= last_done;
            if (rd_done) begin
                sample_index <= idx_q;
                sample_data  <= rd_fail ? '0 : bus.wb_data_read;
                sample_error <= rd_fail;
            end
        end
    end
endmodule
